// File: rtl/jtframe_ioctl_prog.sv
// Byte-to-word ROM download packer: ioctl byte stream -> masked 16-bit SDRAM writes through a small FIFO.
// Optional macro JTFRAME_DWNLD_SWAP_EN inverts the byte-lane mapping for big-endian ROMs.
module jtframe_ioctl_prog #(
    parameter int unsigned SDRAMW    = 23,
    parameter int unsigned HEADER    = 0,
    parameter logic [24:0] BA1_START = 25'h100_0000,
    parameter logic [24:0] BA2_START = 25'h180_0000,
    parameter logic [24:0] BA3_START = 25'h1C0_0000,
    parameter int unsigned FIFO_AW   = 2
) (
    input  logic              clk_rom,
    input  logic              rst_n,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic [1:0]        prog_mask,
    output logic [1:0]        prog_ba,
    output logic              prog_we,
    input  logic              prog_ack,
    output logic              dwnld_busy,
    output logic              overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
`ifdef JTFRAME_DWNLD_SWAP_EN
    localparam logic LANE_SWAP = 1'b1;
`else
    localparam logic LANE_SWAP = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]        ba;
        logic [SDRAMW-1:0] word;
        logic              lsb;
        logic [7:0]        data;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_GAP} state_t;

    entry_t             r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    state_t             r_state;
    logic               r_dl_d;

    logic [24:0] w_off;
    logic [24:0] w_base;
    logic [24:0] w_rel;
    logic [1:0]  w_ba;
    logic        w_accept;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    entry_t      w_entry;
    entry_t      w_head;

    // Address decode: strip header, pick bank, make bank-relative word address
    always_comb begin
        w_off  = ioctl_addr - 25'(HEADER);
        w_ba   = 2'd0;
        w_base = '0;
        if (w_off >= BA3_START) begin
            w_ba   = 2'd3;
            w_base = BA3_START;
        end else if (w_off >= BA2_START) begin
            w_ba   = 2'd2;
            w_base = BA2_START;
        end else if (w_off >= BA1_START) begin
            w_ba   = 2'd1;
            w_base = BA1_START;
        end
        w_rel        = w_off - w_base;
        w_entry.ba   = w_ba;
        w_entry.word = SDRAMW'(w_rel >> 1);
        w_entry.lsb  = w_rel[0];
        w_entry.data = ioctl_dout;
    end

    // Pop looks only at registered occupancy, so an empty FIFO never pops a same-cycle push
    always_comb begin
        w_accept = downloading & ioctl_wr & (ioctl_addr >= 25'(HEADER));
        w_full   = (r_count == FULL_CNT);
        w_pop    = (r_state == ST_IDLE) & (r_count != '0);
        w_push   = w_accept & (~w_full | w_pop);
        w_drop   = w_accept & w_full & ~w_pop;
        w_head   = r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk_rom) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: load head, hold request until ack, then one idle gap cycle
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_ba   <= '0;
            prog_mask <= 2'b11;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        prog_addr <= w_head.word;
                        prog_data <= {w_head.data, w_head.data};
                        prog_ba   <= w_head.ba;
                        prog_mask <= (w_head.lsb ^ LANE_SWAP) ? 2'b01 : 2'b10;
                        prog_we   <= 1'b1;
                        r_state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (prog_ack) begin
                        prog_we <= 1'b0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_d     <= 1'b0;
            overflow   <= 1'b0;
            dwnld_busy <= 1'b0;
        end else begin
            r_dl_d     <= downloading;
            dwnld_busy <= downloading | (r_count != '0) | (r_state != ST_IDLE);
            if (w_drop)
                overflow <= 1'b1;
            else if (downloading & ~r_dl_d)
                overflow <= 1'b0;
        end
    end

endmodule
